// File: rtl/dla_acl_ecc_pkg.sv
// Shared definitions for the ECC background scrubber.
//   ECC_SCRUB_CNT_WIDTH : width of the saturating SEC/DED event counters.
//   ecc_scrub_state_t   : scrubber FSM state encoding.
package dla_acl_ecc_pkg;

    localparam int ECC_SCRUB_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,  // scrubbing disabled, address retained
        INTERVAL  = 3'd1,  // idle gap between word scrubs
        READ      = 3'd2,  // waiting for a free port to issue the read
        WAIT_DATA = 3'd3,  // read in flight through RAM + decoder
        WRITEBACK = 3'd4   // waiting for a free port to write corrected data
    } ecc_scrub_state_t;

endpackage

// File: rtl/dla_acl_ecc_scrub_cnt.sv
// Saturating event counter with synchronous clear.
//   clock, resetn : clock, asynchronous active-low reset
//   i_inc         : count one event this cycle
//   i_clear       : clear; an event in the same cycle leaves the count at 1
//   o_count       : current count, sticks at all-ones
module dla_acl_ecc_scrub_cnt
    import dla_acl_ecc_pkg::*;
(
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           i_inc,
    input  logic                           i_clear,
    output logic [ECC_SCRUB_CNT_WIDTH-1:0] o_count
);

    localparam int W = ECC_SCRUB_CNT_WIDTH;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        // NOTE: default to the held value first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (i_clear) begin
            count_d = i_inc ? W'(1) : '0;
        end else if (i_inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/dla_acl_ecc_scrubber.sv
// Background ECC scrubber: walks the RAM one word at a time, reads each word
// through the ECC decoder, writes back corrected data on single-bit errors,
// counts SEC/DED events and captures the address of the first DED.
//   clock, resetn                       : clock, asynchronous active-low reset
//   i_enable                            : scrubbing runs while high
//   i_port_busy                         : user owns the RAM port this cycle
//   i_user_wr_en/i_user_wr_addr         : snooped user writes (invalidate write-back)
//   o_rd_en/o_rd_addr                   : scrub read request
//   i_rd_data, i_single_error_corrected,
//   i_double_error_detected             : decoder output, READ_LATENCY after o_rd_en
//   o_wr_en/o_wr_addr/o_wr_data         : corrected-data write-back
//   i_clear                             : clears counters and the DED capture
//   o_sec_count/o_ded_count             : saturating event counters
//   o_ded_valid/o_ded_addr              : sticky first-DED capture
//   o_pass_done                         : pulse when the last word of a pass completes
module dla_acl_ecc_scrubber
    import dla_acl_ecc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WORDS      = 2 ** ADDR_WIDTH,
    parameter int READ_LATENCY   = 3,
    parameter int SCRUB_INTERVAL = 256
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           i_enable,
    input  logic                           i_port_busy,
    input  logic                           i_user_wr_en,
    input  logic [ADDR_WIDTH-1:0]          i_user_wr_addr,
    output logic                           o_rd_en,
    output logic [ADDR_WIDTH-1:0]          o_rd_addr,
    input  logic [DATA_WIDTH-1:0]          i_rd_data,
    input  logic                           i_single_error_corrected,
    input  logic                           i_double_error_detected,
    output logic                           o_wr_en,
    output logic [ADDR_WIDTH-1:0]          o_wr_addr,
    output logic [DATA_WIDTH-1:0]          o_wr_data,
    input  logic                           i_clear,
    output logic [ECC_SCRUB_CNT_WIDTH-1:0] o_sec_count,
    output logic [ECC_SCRUB_CNT_WIDTH-1:0] o_ded_count,
    output logic                           o_ded_valid,
    output logic [ADDR_WIDTH-1:0]          o_ded_addr,
    output logic                           o_pass_done
);

    localparam int                    IW        = $clog2(SCRUB_INTERVAL + 2);
    localparam int                    LW        = $clog2(READ_LATENCY + 1);
    localparam logic [IW-1:0]         IVL_LOAD  = IW'(SCRUB_INTERVAL);
    localparam logic [LW-1:0]         LAT_LOAD  = LW'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    ecc_scrub_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [IW-1:0]           ivl_q, ivl_d;
    logic [LW-1:0]           lat_q, lat_d;
    logic                    inv_q, inv_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    ded_valid_q, ded_valid_d;
    logic [ADDR_WIDTH-1:0]   ded_addr_q, ded_addr_d;

    logic user_hit;
    logic rd_issue;
    logic sample;
    logic sec_evt;
    logic ded_evt;
    logic wb_cancel;
    logic wr_issue;
    logic word_done;

    // A user write to the scrub address makes the captured data stale.
    assign user_hit  = i_user_wr_en && (i_user_wr_addr == addr_q);
    assign rd_issue  = (state_q == READ) && !i_port_busy;
    assign sample    = (state_q == WAIT_DATA) && (lat_q == '0);
    // Both status bits set is treated as an uncorrectable error only.
    assign sec_evt   = sample && i_single_error_corrected && !i_double_error_detected;
    assign ded_evt   = sample && i_double_error_detected;
    assign wb_cancel = inv_q || user_hit;
    assign wr_issue  = (state_q == WRITEBACK) && !i_port_busy && !wb_cancel;
    // A word ends at sampling unless a live write-back is pending, otherwise
    // when the write-back issues or is cancelled.
    assign word_done = (sample && !(sec_evt && !wb_cancel)) ||
                       ((state_q == WRITEBACK) && (wb_cancel || !i_port_busy));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ivl_d   = ivl_q;
        lat_d   = lat_q;
        inv_d   = inv_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = INTERVAL;
                    ivl_d   = IVL_LOAD;
                end
            end
            INTERVAL: begin
                // No word is in progress yet, so disabling stops immediately.
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (ivl_q == '0) begin
                    state_d = READ;
                end else begin
                    ivl_d = ivl_q - 1'b1;
                end
            end
            READ: begin
                if (!i_port_busy) begin
                    state_d = WAIT_DATA;
                    lat_d   = LAT_LOAD;
                    inv_d   = user_hit;
                end
            end
            WAIT_DATA: begin
                if (user_hit) begin
                    inv_d = 1'b1;
                end
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else if (sec_evt && !wb_cancel) begin
                    state_d = WRITEBACK;
                    data_d  = i_rd_data;
                end
            end
            WRITEBACK: begin
                if (user_hit) begin
                    inv_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (word_done) begin
            addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            state_d = i_enable ? INTERVAL : IDLE;
            ivl_d   = IVL_LOAD;
        end
    end

    // First-DED capture; a clear in the same cycle as a DED re-arms and recaptures.
    always_comb begin
        ded_valid_d = ded_valid_q;
        ded_addr_d  = ded_addr_q;
        if (i_clear) begin
            ded_valid_d = ded_evt;
            ded_addr_d  = ded_evt ? addr_q : '0;
        end else if (ded_evt && !ded_valid_q) begin
            ded_valid_d = 1'b1;
            ded_addr_d  = addr_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ivl_q       <= '0;
            lat_q       <= '0;
            inv_q       <= 1'b0;
            data_q      <= '0;
            ded_valid_q <= 1'b0;
            ded_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ivl_q       <= ivl_d;
            lat_q       <= lat_d;
            inv_q       <= inv_d;
            data_q      <= data_d;
            ded_valid_q <= ded_valid_d;
            ded_addr_q  <= ded_addr_d;
        end
    end

    dla_acl_ecc_scrub_cnt u_sec_cnt (
        .clock   (clock),
        .resetn  (resetn),
        .i_inc   (sec_evt),
        .i_clear (i_clear),
        .o_count (o_sec_count)
    );

    dla_acl_ecc_scrub_cnt u_ded_cnt (
        .clock   (clock),
        .resetn  (resetn),
        .i_inc   (ded_evt),
        .i_clear (i_clear),
        .o_count (o_ded_count)
    );

    // Requests are gated by i_port_busy combinationally so they issue in the
    // very cycle the port frees up.
    assign o_rd_en     = rd_issue;
    assign o_rd_addr   = addr_q;
    assign o_wr_en     = wr_issue;
    assign o_wr_addr   = addr_q;
    assign o_wr_data   = data_q;
    assign o_ded_valid = ded_valid_q;
    assign o_ded_addr  = ded_addr_q;
    assign o_pass_done = word_done && (addr_q == LAST_ADDR);

endmodule
